pipeline_ctrl: RTL and testbench
================================

Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB). It drives the write-enable and flush of every 128-bit pipeline register (ifid, idex, exmem, memwr) and the PC enable. Inputs are decoded control bits from the stage decoders, plus a data-memory ready handshake.
It resolves four conditions:
- load-use hazards
- taken branches/jumps
- multi-cycle mult/div occupancy of EX
- data-memory wait states

Parameters:
MD_LATENCY, 4, total EX cycles a mult/div occupies (>=1; 1 = no stall)
MEM_TIMEOUT, 255, MEM_WAIT cycles before mem_err is raised
CNT_W, 32, stall counter width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
ifid_rs  in  5  rs field of instruction in ID
ifid_rt  in  5  rt field of instruction in ID
ifid_uses_rt  in  1  ID instruction reads rt as a source
idex_rt  in  5  destination rt of instruction in EX
idex_memtoreg  in  1  EX instruction is a load (lw/lb/lbu)
idex_md  in  1  EX instruction is mult/div
branch_taken  in  1  EX resolved a taken branch/jump/jr
mem_req  in  1  MEM stage performs load/store this cycle
mem_ready  in  1  data memory completes the access this cycle
pc_en  out  1  PC update enable
ifid_en  out  1  ifid register load enable
ifid_flush  out  1  ifid register loads bubble (all zero)
idex_en  out  1  idex load enable
idex_flush  out  1  idex loads bubble
exmem_en  out  1  exmem load enable
exmem_flush  out  1  exmem loads bubble
memwr_en  out  1  memwr load enable
mem_err  out  1  sticky memory timeout flag
stall_cnt  out  CNT_W  cycles with pc_en=0, saturating

Behaviour:
- One clock (clk); reset (rst) is synchronous and active-high.
- While rst=1 (combinational override):
  - all *_en=0, all *_flush=1, mem_err=0, stall_cnt=0.
  - Next state RUN, md_cnt=0, wait_cnt=0.
- Flush has priority over en at the pipeline register: flush=1 loads zero regardless of en.
- Outputs are combinational from state + inputs; state and counters are registered.
- load_use = idex_memtoreg & (idex_rt!=0) & (idex_rt==ifid_rs | (ifid_uses_rt & idex_rt==ifid_rt)).

States: RUN, MD_BUSY, MEM_WAIT. RUN rules, in priority order:
1. mem_req & !mem_ready: all en=0, no flush; wait_cnt<=1; -> MEM_WAIT.
2. idex_md & MD_LATENCY>1:
   - pc_en=ifid_en=idex_en=0
   - exmem_flush=1, memwr_en=1
   - md_cnt<=MD_LATENCY-2; -> MD_BUSY.
3. branch_taken: all en=1, ifid_flush=1, idex_flush=1 (2 squashed slots); stay RUN.
4. load_use: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwr_en=1; one bubble only, because the condition clears once the load moves to MEM.
5. Otherwise: all en=1, no flush.

MD_BUSY:
- md_cnt!=0: outputs as rule 2, md_cnt<=md_cnt-1.
- md_cnt==0 (release cycle): outputs and next state from RUN rules 3-5 with idex_md ignored; -> RUN.
- mem_req is ignored (MEM holds a bubble).

MEM_WAIT:
- mem_ready=0: all en=0, no flush. wait_cnt increments, saturating at MEM_TIMEOUT. wait_cnt==MEM_TIMEOUT sets mem_err=1, which stays set until rst.
- mem_ready=1: apply RUN rules 2-5 (outputs and transition); wait_cnt<=0.

Frozen inputs:
- A branch_taken or load_use arriving while frozen is held stable by the frozen idex register.
- It is serviced in the release cycle, not before.

stall_cnt increments every non-reset cycle with pc_en=0; it holds at 2^CNT_W-1.

Reset in MD_BUSY or MEM_WAIT aborts immediately; the next cycle is RUN with counters cleared.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - state encoding (2-bit, RUN=0, MD_BUSY=1, MEM_WAIT=2)
  - REG_ZERO=5'd0
  - opcode/funct constants shared with the stage decoders
- One natural sub-module: sat_counter (parameterised width, enable, sync clear, saturate). Used for stall_cnt and wait_cnt.

Test Plan:
- Load-use: idex_memtoreg=1, idex_rt=8, ifid_rs=8 -> exactly one cycle of pc_en=0, ifid_en=0, idex_flush=1, then normal flow; stall_cnt=1. Repeat with idex_rt=0 -> no stall.
- Branch: branch_taken=1 for one cycle -> ifid_flush=idex_flush=1, pc_en=1 that cycle; stall_cnt unchanged.
- Mult/div with MD_LATENCY=4:
  - idex_md=1 -> pc_en=0 for 3 cycles, exmem_flush=1 for 3 cycles, release on the 4th.
  - Back-to-back md instructions -> 6 stall cycles total.
- Memory wait: mem_req=1, mem_ready=0 for 5 cycles, then 1 -> all en=0 for 5 cycles, advance on cycle 6; stall_cnt=5. Simultaneous load_use during the wait is serviced on the release cycle (1 extra stall).
- Timeout with MEM_TIMEOUT=8: mem_ready held 0 -> mem_err=1 after 8 MEM_WAIT cycles and stays 1 after mem_ready; only rst clears it.
- Reset mid-MD_BUSY (md_cnt=1): rst=1 -> all flushes 1, stall_cnt=0. After rst drops: RUN, all en=1.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer and the stage decoders.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MD_BUSY  = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Opcode / funct values the stage decoders use to produce the control bits.
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;

  // Enable/flush bundle driven to the pipeline registers.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwr_en;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  localparam ctrl_t CTRL_NORMAL   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam ctrl_t CTRL_FREEZE   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_MD_STALL = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam ctrl_t CTRL_BRANCH   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam ctrl_t CTRL_LOAD_USE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  // A load in EX whose destination is read by the instruction in ID.
  function automatic logic load_use_hazard(input logic memtoreg, input logic [4:0] ex_rt,
                                           input logic [4:0] id_rs, input logic [4:0] id_rt,
                                           input logic uses_rt);
    return memtoreg && (ex_rt != REG_ZERO) &&
           ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Decoder-to-sequencer control bits and sequencer-to-pipeline enables.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       ifid_rs;
  logic [4:0]       ifid_rt;
  logic             ifid_uses_rt;
  logic [4:0]       idex_rt;
  logic             idex_memtoreg;
  logic             idex_md;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             exmem_flush;
  logic             memwr_en;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  // Pipeline / decoder side
  modport master (
    output ifid_rs, ifid_rt, ifid_uses_rt, idex_rt, idex_memtoreg, idex_md,
           branch_taken, mem_req, mem_ready,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
           memwr_en, mem_err, stall_cnt
  );

  // Sequencer side
  modport slave (
    input  ifid_rs, ifid_rt, ifid_uses_rt, idex_rt, idex_memtoreg, idex_md,
           branch_taken, mem_req, mem_ready,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush,
           memwr_en, mem_err, stall_cnt
  );
endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Up-counter with synchronous clear and saturation at MAX.
module sat_counter #(
  parameter int           W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  // Clear wins over count; the count sticks once it reaches MAX.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, taken branch,
// multi-cycle mult/div and data-memory wait handling.
//
// state       | meaning
// ST_RUN      | normal issue; hazards resolved in priority order
// ST_MD_BUSY  | mult/div occupies EX; md_cnt stall cycles left before release
// ST_MEM_WAIT | data memory access outstanding; whole pipe frozen
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MD_LATENCY  = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  pipeline_ctrl_if.slave     bus
);

  localparam int MD_W   = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [MD_W-1:0]   md_cnt, md_cnt_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  stall_q;
  ctrl_t             ctrl;
  logic              wait_inc, wait_clr;
  logic              err_q, err_set;
  logic              issue, md_allowed;
  logic              load_use;

  // Next state, counter control and enable/flush decode.
  always_comb begin
    ctrl       = CTRL_NORMAL;
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    wait_inc   = 1'b0;
    wait_clr   = 1'b0;
    err_set    = 1'b0;
    issue      = 1'b0;
    md_allowed = 1'b0;
    load_use   = load_use_hazard(bus.idex_memtoreg, bus.idex_rt, bus.ifid_rs,
                                 bus.ifid_rt, bus.ifid_uses_rt);

    case (state)
      ST_RUN: begin
        if (bus.mem_req && !bus.mem_ready) begin
          ctrl      = CTRL_FREEZE;
          wait_inc  = 1'b1;
          state_nxt = ST_MEM_WAIT;
        end else begin
          issue      = 1'b1;
          md_allowed = 1'b1;
        end
      end
      ST_MD_BUSY: begin
        if (md_cnt != '0) begin
          ctrl       = CTRL_MD_STALL;
          md_cnt_nxt = md_cnt - 1'b1;
        end else begin
          // Release: the md instruction still sits in EX, so idex_md is ignored.
          issue = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        err_set = (wait_cnt == WAIT_W'(MEM_TIMEOUT));
        if (!bus.mem_ready) begin
          ctrl     = CTRL_FREEZE;
          wait_inc = 1'b1;
        end else begin
          wait_clr   = 1'b1;
          issue      = 1'b1;
          md_allowed = 1'b1;
        end
      end
      default: state_nxt = ST_RUN;
    endcase

    if (issue) begin
      state_nxt = ST_RUN;
      if (md_allowed && bus.idex_md && (MD_LATENCY > 1)) begin
        ctrl       = CTRL_MD_STALL;
        md_cnt_nxt = MD_W'(MD_LATENCY - 2);
        state_nxt  = ST_MD_BUSY;
      end else if (bus.branch_taken) begin
        ctrl = CTRL_BRANCH;
      end else if (load_use) begin
        ctrl = CTRL_LOAD_USE;
      end
    end

    if (rst) begin
      ctrl       = CTRL_RESET;
      state_nxt  = ST_RUN;
      md_cnt_nxt = '0;
      err_set    = 1'b0;
    end
  end

  // State, mult/div countdown and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_RUN;
      md_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
      if (err_set) err_q <= 1'b1;
    end
  end

  sat_counter #(.W(WAIT_W), .MAX(WAIT_W'(MEM_TIMEOUT))) u_wait_cnt (
    .clk (clk),
    .clr (rst | wait_clr),
    .en  (wait_inc),
    .cnt (wait_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (rst),
    .en  (!ctrl.pc_en),
    .cnt (stall_q)
  );

  assign bus.pc_en       = ctrl.pc_en;
  assign bus.ifid_en     = ctrl.ifid_en;
  assign bus.ifid_flush  = ctrl.ifid_flush;
  assign bus.idex_en     = ctrl.idex_en;
  assign bus.idex_flush  = ctrl.idex_flush;
  assign bus.exmem_en    = ctrl.exmem_en;
  assign bus.exmem_flush = ctrl.exmem_flush;
  assign bus.memwr_en    = ctrl.memwr_en;
  assign bus.mem_err     = !rst && (err_q || err_set);
  assign bus.stall_cnt   = rst ? '0 : stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
module tb_pipeline_ctrl;

  localparam int MD_LAT = 4;
  localparam int TO     = 8;
  localparam int CW     = 8;
  localparam longint SMAX = (64'd1 << CW) - 1;

  // Enable/flush vectors: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwr_en}
  localparam logic [7:0] V_RESET  = 8'b0010_1010;
  localparam logic [7:0] V_NORMAL = 8'b1101_0101;
  localparam logic [7:0] V_FREEZE = 8'b0000_0000;
  localparam logic [7:0] V_MD     = 8'b0000_0011;
  localparam logic [7:0] V_BRANCH = 8'b1111_1101;
  localparam logic [7:0] V_LU     = 8'b0000_1101;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pipeline_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_ctrl #(.MD_LATENCY(MD_LAT), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0] dut_c;
  assign dut_c = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush,
                  bus.exmem_en, bus.exmem_flush, bus.memwr_en};

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: tracks how long a mult/div has been in EX, whether a
  // memory access is outstanding and how many wait cycles it has taken.
  bit     m_md = 0;
  int     m_md_age = 0;
  bit     m_mem = 0;
  int     m_waited = 0;
  bit     m_err = 0;
  longint m_stalls = 0;

  always @(negedge clk) begin
    logic [7:0] exp_c;
    bit         exp_err, lu, md_ok, mem_ok;
    longint     exp_sc;
    if (rst) begin
      exp_c = V_RESET; exp_err = 0; exp_sc = 0;
      m_md = 0; m_md_age = 0; m_mem = 0; m_waited = 0; m_err = 0; m_stalls = 0;
    end else begin
      lu = bus.idex_memtoreg && bus.idex_rt != 0 &&
           (bus.idex_rt == bus.ifid_rs || (bus.ifid_uses_rt && bus.idex_rt == bus.ifid_rt));
      exp_sc  = m_stalls;
      exp_err = m_err || (m_mem && m_waited == TO);
      m_err   = exp_err;
      if (m_md && m_md_age < MD_LAT - 1) begin
        exp_c = V_MD;
        m_md_age++;
      end else if (m_mem && !bus.mem_ready) begin
        exp_c = V_FREEZE;
        if (m_waited < TO) m_waited++;
      end else begin
        md_ok  = !m_md;
        mem_ok = !m_md && !m_mem;
        m_md = 0; m_mem = 0; m_waited = 0;
        if (mem_ok && bus.mem_req && !bus.mem_ready) begin
          exp_c = V_FREEZE; m_mem = 1; m_waited = 1;
        end else if (md_ok && bus.idex_md && MD_LAT > 1) begin
          exp_c = V_MD; m_md = 1; m_md_age = 1;
        end else if (bus.branch_taken) begin
          exp_c = V_BRANCH;
        end else if (lu) begin
          exp_c = V_LU;
        end else begin
          exp_c = V_NORMAL;
        end
      end
      if (!exp_c[7] && m_stalls < SMAX) m_stalls++;
    end
    check("model_ctrl", dut_c, exp_c);
    check("model_mem_err", bus.mem_err, exp_err);
    check("model_stall_cnt", bus.stall_cnt, exp_sc);
  end

  task automatic idle();
    bus.ifid_rs = 5'd1; bus.ifid_rt = 5'd2; bus.ifid_uses_rt = 1'b0;
    bus.idex_rt = 5'd3; bus.idex_memtoreg = 1'b0; bus.idex_md = 1'b0;
    bus.branch_taken = 1'b0; bus.mem_req = 1'b0; bus.mem_ready = 1'b1;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_load_use();
    bus.idex_memtoreg = 1'b1; bus.idex_rt = 5'd8; bus.ifid_rs = 5'd8;
  endtask

  initial begin
    int n_stall, n_xflush, n_frozen;
    rst = 1'b1;
    idle();
    adv(); mid();
    check("reset_ctrl", dut_c, V_RESET);
    check("reset_stall_cnt", bus.stall_cnt, 0);
    adv();
    rst = 1'b0;
    mid();
    check("run_normal", dut_c, V_NORMAL);
    adv();

    // Load-use: exactly one bubble
    set_load_use();
    mid(); check("load_use", dut_c, V_LU); adv();
    idle();
    mid(); check("load_use_after", dut_c, V_NORMAL);
    check("load_use_stall_cnt", bus.stall_cnt, 1); adv();
    bus.idex_memtoreg = 1'b1; bus.idex_rt = 5'd0; bus.ifid_rs = 5'd0;
    mid(); check("load_rt0_no_stall", dut_c, V_NORMAL); adv();
    idle();

    // Taken branch
    bus.branch_taken = 1'b1;
    mid(); check("branch", dut_c, V_BRANCH); adv();
    idle();
    mid(); check("branch_stall_cnt", bus.stall_cnt, 1); adv();

    // Single mult/div
    bus.idex_md = 1'b1;
    n_stall = 0; n_xflush = 0;
    for (int i = 0; i < 4; i++) begin
      mid();
      if (!bus.pc_en) n_stall++;
      if (bus.exmem_flush) n_xflush++;
      if (i == 3) check("md_release_pc_en", bus.pc_en, 1);
      adv();
    end
    check("md_stall_cycles", n_stall, 3);
    check("md_exmem_flush_cycles", n_xflush, 3);
    idle();
    mid(); check("md_stall_cnt", bus.stall_cnt, 4); adv();

    // Back-to-back mult/div
    bus.idex_md = 1'b1;
    n_stall = 0;
    for (int i = 0; i < 8; i++) begin
      mid(); if (!bus.pc_en) n_stall++; adv();
    end
    check("md_b2b_stalls", n_stall, 6);
    idle();
    mid(); check("md_b2b_stall_cnt", bus.stall_cnt, 10); adv();

    // Memory wait of 5 cycles
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    n_frozen = 0;
    for (int i = 0; i < 5; i++) begin
      mid(); if (dut_c == V_FREEZE) n_frozen++; adv();
    end
    check("mem_wait_frozen", n_frozen, 5);
    bus.mem_ready = 1'b1;
    mid(); check("mem_wait_release", dut_c, V_NORMAL); adv();
    idle();
    mid(); check("mem_wait_stall_cnt", bus.stall_cnt, 15); adv();

    // Load-use held during a memory wait is serviced on release
    set_load_use(); bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid(); adv();
    end
    bus.mem_ready = 1'b1;
    mid(); check("mem_release_load_use", dut_c, V_LU); adv();
    idle();
    mid(); check("mem_lu_after", dut_c, V_NORMAL);
    check("mem_lu_stall_cnt", bus.stall_cnt, 19); adv();

    // Timeout
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mid();
      if (i == 7) check("timeout_not_yet", bus.mem_err, 0);
      if (i == 8) check("timeout_raised", bus.mem_err, 1);
      adv();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      mid(); adv();
    end
    mid(); check("timeout_sticky", bus.mem_err, 1); adv();
    rst = 1'b1;
    mid(); check("timeout_rst_clears", bus.mem_err, 0); adv();
    rst = 1'b0;
    mid(); check("timeout_after_rst", bus.mem_err, 0); adv();

    // Reset in the middle of a mult/div
    bus.idex_md = 1'b1;
    mid(); adv(); mid(); adv();
    rst = 1'b1;
    mid(); check("md_abort_ctrl", dut_c, V_RESET);
    check("md_abort_stall_cnt", bus.stall_cnt, 0); adv();
    rst = 1'b0; idle();
    mid(); check("md_abort_run", dut_c, V_NORMAL); adv();

    // Stall counter saturation
    bus.mem_req = 1'b1; bus.mem_ready = 1'b0;
    for (int i = 0; i < 300; i++) begin
      mid(); adv();
    end
    mid(); check("stall_cnt_saturates", bus.stall_cnt, SMAX); adv();
    idle(); rst = 1'b1; adv(); rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst               = ($urandom_range(0, 199) == 0);
      bus.ifid_rs       = 5'($urandom_range(0, 3));
      bus.ifid_rt       = 5'($urandom_range(0, 3));
      bus.ifid_uses_rt  = 1'($urandom_range(0, 1));
      bus.idex_rt       = 5'($urandom_range(0, 3));
      bus.idex_memtoreg = ($urandom_range(0, 2) == 0);
      bus.idex_md       = ($urandom_range(0, 7) == 0);
      bus.branch_taken  = ($urandom_range(0, 5) == 0);
      bus.mem_req       = ($urandom_range(0, 2) == 0);
      bus.mem_ready     = ($urandom_range(0, 2) != 0);
      adv();
    end
    rst = 1'b0; idle();
    adv(); adv();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
